// File: rtl/mem_hold_ctrl_pkg.sv
// rtl/mem_hold_ctrl_pkg.sv - shared state encoding and constants for the memory-stage hold controller
package mem_hold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // SelC value the control unit injects while HOLD is high; a bubble never raises MR/MW
  localparam logic [5:0] BUBBLE_SELC = 6'd35;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic int timer_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic logic is_bubble(input logic [5:0] selc);
    return selc == BUBBLE_SELC;
  endfunction

endpackage

// File: rtl/mem_hold_ctrl_if.sv
// rtl/mem_hold_ctrl_if.sv - request/acknowledge bus between the hold controller and data memory
interface mem_hold_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - clearable up-counter flagging the last cycle of the ack wait window
module mem_wait_timer
  import mem_hold_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = timer_w(TIMEOUT);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Cleared on every BUSY entry, so it stops leaving BUSY long before it could wrap
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_hold_ctrl.sv
// rtl/mem_hold_ctrl.sv - stalls the pipeline while a single load/store handshakes with data memory
module mem_hold_ctrl
  import mem_hold_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MR_IN,
  input  logic              MW_IN,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              HOLD,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rd_valid,
  output logic              bus_err,
  output logic              req_conflict,
  mem_hold_ctrl_if.master   mem
);

  mem_state_t state, state_nxt;

  logic req_any;
  logic accept;
  logic ack_hit;
  logic timeout_hit;
  logic timer_tc;

  assign req_any     = MR_IN | MW_IN;
  assign accept      = (state == IDLE) && req_any;
  assign ack_hit     = (state == BUSY) && mem.mem_ack;
  // An ack landing on the terminal count still completes the access normally
  assign timeout_hit = (state == BUSY) && !mem.mem_ack && timer_tc;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (accept),
    .en   (state == BUSY),
    .tc   (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = BUSY;
      BUSY:    if (ack_hit || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // HOLD rises combinationally in IDLE so the bubble lands in the request cycle itself
  always_comb begin
    HOLD = 1'b0;
    case (state)
      IDLE:    HOLD = req_any;
      BUSY:    HOLD = 1'b1;
      DONE:    HOLD = 1'b0;
      default: HOLD = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_out     <= '0;
      rd_valid      <= 1'b0;
      bus_err       <= 1'b0;
      req_conflict  <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      rd_valid     <= 1'b0;
      bus_err      <= 1'b0;
      req_conflict <= 1'b0;
      if (accept) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= MW_IN & ~MR_IN;
        mem.mem_addr  <= addr_in;
        mem.mem_wdata <= wdata_in;
        req_conflict  <= MR_IN & MW_IN;
      end
      if (ack_hit) begin
        mem.mem_req <= 1'b0;
        if (!mem.mem_we) begin
          rdata_out <= mem.mem_rdata;
          rd_valid  <= 1'b1;
        end
      end else if (timeout_hit) begin
        mem.mem_req <= 1'b0;
        bus_err     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_hold_ctrl.sv
// tb/tb_mem_hold_ctrl.sv - scoreboard bench for mem_hold_ctrl with randomized load/store traffic
module tb_mem_hold_ctrl;
  import mem_hold_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MR_IN, MW_IN;
  logic [31:0] addr_in, wdata_in;
  logic        HOLD;
  logic [31:0] rdata_out;
  logic        rd_valid, bus_err, req_conflict;

  mem_hold_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  mem_hold_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .MR_IN       (MR_IN),
    .MW_IN       (MW_IN),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .HOLD        (HOLD),
    .rdata_out   (rdata_out),
    .rd_valid    (rd_valid),
    .bus_err     (bus_err),
    .req_conflict(req_conflict),
    .mem         (mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          hold_len;
    int          req_len;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        conflict;
    logic        rdv;
    logic        berr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          n_issued = 0;
  int          n_rise = 0;
  logic [31:0] model_rdata = '0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One instruction: request in cycle 0, ack in cycle k (k=0: never). Returns in the cycle after DONE.
  task automatic do_access(input bit rd, input bit wr, input int k,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat);
    exp_t e;
    bit   acked;
    acked      = (k >= 1) && (k <= TO);
    e.we       = wr & ~rd;
    e.addr     = a;
    e.wdata    = d;
    e.conflict = rd & wr;
    e.hold_len = acked ? k + 1 : TO + 1;
    e.req_len  = acked ? k : TO;
    e.rdv      = acked && rd;
    e.berr     = !acked;
    if (acked && rd) model_rdata = rdat;
    e.rdata    = model_rdata;
    exp_q.push_back(e);
    n_issued++;
    MR_IN = rd;
    MW_IN = wr;
    addr_in = a;
    wdata_in = d;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = $urandom;
    for (int c = 1; c <= e.hold_len; c++) begin
      @(posedge clk); #1;
      mem_bus.mem_ack   = (c == k);
      mem_bus.mem_rdata = (c == k) ? rdat : $urandom;
    end
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    MR_IN = 1'b0;
    MW_IN = 1'b0;
  endtask

  int          run = 0;
  int          reqn = 0;
  bit          seen_conf = 1'b0;
  bit          cap = 1'b0;
  logic        we_c;
  logic [31:0] a_c, d_c;
  logic        req_prev = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        run = 0; reqn = 0; seen_conf = 1'b0; cap = 1'b0; req_prev = mem_bus.mem_req;
        continue;
      end
      if (mem_bus.mem_req && !req_prev) n_rise++;
      req_prev = mem_bus.mem_req;
      if (HOLD) begin
        run++;
        if (mem_bus.mem_req) begin
          reqn++;
          if (!cap) begin
            cap = 1'b1; we_c = mem_bus.mem_we; a_c = mem_bus.mem_addr; d_c = mem_bus.mem_wdata;
          end
        end
        if (req_conflict) seen_conf = 1'b1;
        check("busy_pulses", {30'd0, rd_valid, bus_err}, 32'd0);
      end else if (run > 0) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_access: got hold run %0d expected none", run);
        end else begin
          e = exp_q.pop_front();
          check("hold_len", run, e.hold_len);
          check("req_len", reqn, e.req_len);
          check("mem_we", we_c, e.we);
          check("mem_addr", a_c, e.addr);
          check("mem_wdata", d_c, e.wdata);
          check("req_conflict", seen_conf, e.conflict);
          check("rd_valid", rd_valid, e.rdv);
          check("bus_err", bus_err, e.berr);
          check("rdata_out", rdata_out, e.rdata);
          check("done_mem_req", mem_bus.mem_req, 1'b0);
        end
        run = 0; reqn = 0; seen_conf = 1'b0; cap = 1'b0;
      end else begin
        check("idle_outputs", {28'd0, rd_valid, bus_err, req_conflict, mem_bus.mem_req}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int r, k, gap, n_before;
    reset = 1'b1; MR_IN = 1'b0; MW_IN = 1'b0; addr_in = '0; wdata_in = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold", HOLD, 1'b0);
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_pulses", {29'd0, rd_valid, bus_err, req_conflict}, 32'd0);
    check("rst_mem", {29'd0, mem_bus.mem_req, mem_bus.mem_we, |mem_bus.mem_addr}, 32'd0);
    check("rst_wdata", mem_bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    do_access(1, 0, 3, 32'h40, 32'h0, 32'hDEADBEEF);
    do_access(0, 1, 1, 32'h100, 32'h55, 32'h0);
    do_access(1, 0, 0, 32'h44, 32'h0, 32'h0);
    do_access(1, 1, 2, 32'h48, 32'h99, 32'h12345678);
    do_access(1, 0, TO, 32'h4C, 32'h0, 32'hCAFEF00D);
    do_access(1, 0, TO + 1, 32'h50, 32'h0, 32'hBAD0BAD0);
    n_before = n_rise;
    do_access(1, 0, 1, 32'h60, 32'h0, 32'h11111111);
    do_access(1, 0, 2, 32'h64, 32'h0, 32'h22222222);
    @(negedge clk);
    check("b2b_req_rises", n_rise - n_before, 2);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      r   = $urandom_range(0, 3);
      k   = $urandom_range(0, TO + 1);
      gap = $urandom_range(0, 2);
      do_access(r != 2, r >= 2, k, $urandom, $urandom, $urandom);
      repeat (gap) begin
        mem_bus.mem_ack = $urandom_range(0, 1);
        @(posedge clk); #1;
      end
      mem_bus.mem_ack = 1'b0;
    end

    do_access(1, 0, 2, 32'h80, 32'h0, 32'hA5A5A5A5);
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    check("req_rises_total", n_rise, n_issued);

    mon_en = 1'b0;
    @(posedge clk); #1;
    MR_IN = 1'b1; addr_in = 32'h90;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; MR_IN = 1'b0;
    @(negedge clk);
    check("rst_mid_busy_hold", HOLD, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_req", mem_bus.mem_req, 1'b0);
    check("rst_mid_hold", HOLD, 1'b0);
    check("rst_mid_rdata", rdata_out, 32'd0);
    check("rst_mid_addr", mem_bus.mem_addr, 32'd0);
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_rd_valid", rd_valid, 1'b0);
    check("late_ack_rdata", rdata_out, 32'd0);
    check("late_ack_hold", HOLD, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
